// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module      : run_controller
// Description : Sequences one program run of the processor core. Converts the
//               external req/done handshake into a PC load pulse, the core
//               enable window, a post-halt drain period and run completion,
//               and counts executed RUN cycles (saturating).
//               Optional watchdog: define RUN_CTRL_WATCHDOG_EN to force a stop
//               after WDOG_LIMIT RUN cycles; otherwise timeout is always 0.
// Revision    : 1.0 - initial release
// ============================================================================
module run_controller #(
    parameter int PC_W         = 10,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 2,
    parameter int WDOG_LIMIT   = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             halt,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_load_val,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycles,
    output logic             timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Drain counter only needs to reach DRAIN_CYCLES-1; keep at least one bit.
    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t           state;
    logic             req_q;
    logic [DW-1:0]    drain_cnt;
    logic             rise;
    logic [CNT_W-1:0] cycles_inc;
    logic             wdog_hit;

    // Run start is qualified by a 0->1 transition of the request level.
    assign rise       = req & ~req_q;
    // Count including the current RUN cycle, held at all-ones instead of wrapping.
    assign cycles_inc = (&cycles) ? cycles : cycles + CNT_W'(1);

`ifdef RUN_CTRL_WATCHDOG_EN
    // Limit is reached when this RUN cycle brings the count up to WDOG_LIMIT.
    assign wdog_hit = (32'(cycles_inc) >= 32'(WDOG_LIMIT));
`else
    logic unused_wdog_limit;
    assign wdog_hit          = 1'b0;
    assign unused_wdog_limit = (WDOG_LIMIT == 0);
`endif

    // Run sequencer: state, request edge history and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            drain_cnt   <= '0;
            pc_load     <= 1'b0;
            pc_load_val <= '0;
            core_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycles      <= '0;
            timeout     <= 1'b0;
        end else begin
            req_q <= req;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state       <= LOAD;
                        pc_load_val <= start_addr;
                        pc_load     <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                LOAD: begin
                    state   <= RUN;
                    pc_load <= 1'b0;
                    core_en <= 1'b1;
                    cycles  <= '0;
                    timeout <= 1'b0;
                end
                RUN: begin
                    cycles <= cycles_inc;
                    // halt in the same cycle as the limit wins: no timeout flag.
                    if (halt || wdog_hit) begin
                        core_en   <= 1'b0;
                        timeout   <= ~halt;
                        drain_cnt <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    if (!req) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pc_load <= 1'b0;
                    core_en <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_controller
// Description : Directed self-checking bench for run_controller. Main instance
//               uses DRAIN_CYCLES=2 and WDOG_LIMIT=100; a second instance with
//               CNT_W=4 and DRAIN_CYCLES=0 covers counter saturation and the
//               zero-drain path. Watchdog runs are built when
//               RUN_CTRL_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        halt = 1'b0;
    logic [9:0]  start_addr = '0;
    logic        pc_load, core_en, busy, done, timeout;
    logic [9:0]  pc_load_val;
    logic [15:0] cycles;

    logic        req2 = 1'b0;
    logic        halt2 = 1'b0;
    logic [9:0]  start2 = '0;
    logic        pc_load2, core_en2, busy2, done2, timeout2;
    logic [9:0]  pc_load_val2;
    logic [3:0]  cycles2;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    run_controller #(.PC_W(10), .CNT_W(16), .DRAIN_CYCLES(2), .WDOG_LIMIT(100)) dut (
        .clk(clk), .reset(reset), .req(req), .start_addr(start_addr), .halt(halt),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .core_en(core_en),
        .busy(busy), .done(done), .cycles(cycles), .timeout(timeout)
    );

    run_controller #(.PC_W(10), .CNT_W(4), .DRAIN_CYCLES(0), .WDOG_LIMIT(1000)) dut_sat (
        .clk(clk), .reset(reset), .req(req2), .start_addr(start2), .halt(halt2),
        .pc_load(pc_load2), .pc_load_val(pc_load_val2), .core_en(core_en2),
        .busy(busy2), .done(done2), .cycles(cycles2), .timeout(timeout2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One full run on the main instance; halt raised during the halt_at-th RUN
    // cycle (0 = never). Optionally drops req after the 2nd RUN cycle.
    task automatic run(input logic [9:0] addr, input int halt_at, input bit drop_req,
                       input int exp_en, input logic exp_to);
        int nload = 0;
        int nen = 0;
        int load_c = -1;
        int first_en = -1;
        int last_en = -1;
        int done_c = -1;
        start_addr = addr;
        req = 1'b1;
        halt = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            halt = 1'b0;
            if (pc_load) begin
                nload++;
                load_c = c;
            end
            if (core_en) begin
                nen++;
                last_en = c;
                if (nen == 1) begin
                    first_en = c;
                    check("cycles_cleared", cycles, 0);
                end
                if (nen == halt_at) halt = 1'b1;
                if (drop_req && nen == 2) req = 1'b0;
            end
            check("done_busy_excl", done & busy, 0);
            if (done) begin
                done_c = c;
                break;
            end
        end
        check("done_seen", done, 1);
        check("pc_load_count", nload, 1);
        check("pc_load_latency", load_c, 0);
        check("pc_load_val", pc_load_val, addr);
        check("first_core_en", first_en, 1);
        check("core_en_count", nen, exp_en);
        check("cycles", cycles, exp_en);
        check("done_latency", done_c - last_en, 3);
        check("timeout", timeout, exp_to);
        halt = 1'b0;
    endtask

    initial begin
        int n;
        int last;
        int dc;

        // 1: reset held, then idle with stray halt
        repeat (5) @(posedge clk);
        #1;
        check("rst_pc_load", pc_load, 0);
        check("rst_pc_load_val", pc_load_val, 0);
        check("rst_core_en", core_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cycles", cycles, 0);
        check("rst_timeout", timeout, 0);
        check("rst_sat_cycles", cycles2, 0);
        reset = 1'b0;
        halt = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_core_en", core_en, 0);
        check("idle_pc_load", pc_load, 0);
        check("idle_done", done, 0);
        halt = 1'b0;

        // 2: basic run, halt on 7th RUN cycle
        run(10'h020, 7, 1'b0, 7, 1'b0);

        // 3: done held while req high, released, then rerun from 0x000
        repeat (5) begin
            @(posedge clk); #1;
            check("done_hold", done, 1);
            check("cycles_hold", cycles, 7);
            check("addr_hold", pc_load_val, 10'h020);
        end
        req = 1'b0;
        @(posedge clk); #1;
        check("done_release", done, 0);
        check("busy_release", busy, 0);
        run(10'h000, 4, 1'b0, 4, 1'b0);
        req = 1'b0;
        @(posedge clk); #1;

        // 4: async reset in 3rd RUN cycle, then run with req dropped mid-run
        start_addr = 10'h155;
        req = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(posedge clk); #1;
            if (core_en) n++;
        end
        check("t4_run_reached", n, 3);
        #1 reset = 1'b1;
        #1;
        check("async_core_en", core_en, 0);
        check("async_busy", busy, 0);
        check("async_cycles", cycles, 0);
        check("async_pc_load_val", pc_load_val, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        req = 1'b0;
        @(posedge clk); #1;
        run(10'h3FF, 5, 1'b1, 5, 1'b0);
        @(posedge clk); #1;
        check("drop_req_idle", done, 0);

`ifdef RUN_CTRL_WATCHDOG_EN
        // 5: watchdog expiry, then halt on the limit cycle
        req = 1'b0;
        @(posedge clk); #1;
        run(10'h010, 0, 1'b0, 100, 1'b1);
        req = 1'b0;
        @(posedge clk); #1;
        check("timeout_sticky", timeout, 1);
        run(10'h011, 100, 1'b0, 100, 1'b0);
        req = 1'b0;
        @(posedge clk); #1;
`endif

        // 6: 4-bit counter saturation, zero-drain path
        start2 = 10'h0AB;
        req2 = 1'b1;
        n = 0;
        last = -1;
        dc = -1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            halt2 = 1'b0;
            if (core_en2) begin
                n++;
                last = c;
                if (n == 17) check("sat_early", cycles2, 4'hF);
                if (n == 20) halt2 = 1'b1;
            end
            if (done2) begin
                dc = c;
                break;
            end
        end
        halt2 = 1'b0;
        check("sat_done_seen", done2, 1);
        check("sat_core_en_count", n, 20);
        check("sat_cycles", cycles2, 4'hF);
        check("sat_done_latency", dc - last, 1);
        check("sat_busy", busy2, 0);
        check("sat_pc_load_val", pc_load_val2, 10'h0AB);
        check("sat_timeout", timeout2, 0);
        req2 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
